// File: rtl/cpu_types_pkg.sv
// Shared types for the ALU harness: datapath word, opcode, and the operand-entry FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  aluop_t;

  typedef enum logic [1:0] {
    ENTER_A  = 2'b00,
    ENTER_B  = 2'b01,
    ENTER_OP = 2'b10,
    READY    = 2'b11
  } entry_state_t;

  localparam int OPERAND_SIGN_BIT = 16;

  // Sign bit on SW[16] extends over the whole upper half of the word.
  function automatic word_t operand_value(input logic [16:0] swq);
    return {{16{swq[OPERAND_SIGN_BIT]}}, swq[15:0]};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One active-low pushbutton: synchronize, debounce, and emit a one-cycle pulse on each accepted press.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic CLK,
  input  logic nRST,
  input  logic key_n,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_dly_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  // Released (high) is the idle level everywhere in the chain.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      stable_q     <= 1'b1;
      stable_dly_q <= 1'b1;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= key_n;
      sync2_q      <= sync1_q;
      stable_dly_q <= stable_q;
      press_q      <= stable_dly_q & ~stable_q;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/alu_operand_entry.sv
// Operand/opcode entry front end: debounced keys drive a 4-state FSM that loads porta, portb and aluop.
module alu_operand_entry
  import cpu_types_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [3:0]  KEY,
  input  logic [17:0] SW,
  output word_t       porta,
  output word_t       portb,
  output aluop_t      aluop,
  output logic        ready,
  output logic        alu_go,
  output logic [1:0]  state_led
);

  logic [3:0]   press;
  logic [16:0]  sw_sync1_q;
  logic [16:0]  swq;
  entry_state_t state_q;
  word_t        porta_q;
  word_t        portb_q;
  aluop_t       aluop_q;
  logic         ready_q;
  logic         alu_go_q;
  logic         enter_s;
  logic         clear_s;
  logic         repeat_s;
  logic         unused_inputs_s;

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_key_debounce (
      .CLK  (CLK),
      .nRST (nRST),
      .key_n(KEY[k]),
      .press(press[k])
    );
  end

  assign enter_s         = press[0];
  assign clear_s         = press[1];
  assign repeat_s        = press[2];
  assign unused_inputs_s = ^{press[3], SW[17]};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sw_sync1_q <= '0;
      swq        <= '0;
    end else begin
      sw_sync1_q <= SW[16:0];
      swq        <= sw_sync1_q;
    end
  end

  // Priority: clear over enter over repeat; alu_go is suppressed if it fired last cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ENTER_A;
      porta_q  <= 32'h0000_0000;
      portb_q  <= 32'h0000_0000;
      aluop_q  <= 4'h0;
      ready_q  <= 1'b0;
      alu_go_q <= 1'b0;
    end else begin
      alu_go_q <= 1'b0;
      if (clear_s) begin
        state_q <= ENTER_A;
        porta_q <= 32'h0000_0000;
        portb_q <= 32'h0000_0000;
        aluop_q <= 4'h0;
        ready_q <= 1'b0;
      end else begin
        case (state_q)
          ENTER_A: begin
            if (enter_s) begin
              porta_q <= operand_value(swq);
              state_q <= ENTER_B;
            end
          end
          ENTER_B: begin
            if (enter_s) begin
              portb_q <= operand_value(swq);
              state_q <= ENTER_OP;
            end
          end
          ENTER_OP: begin
            if (enter_s) begin
              aluop_q  <= swq[3:0];
              state_q  <= READY;
              ready_q  <= 1'b1;
              alu_go_q <= 1'b1;
            end
          end
          READY: begin
            if (enter_s) begin
              state_q <= ENTER_A;
              ready_q <= 1'b0;
            end else if (repeat_s && !alu_go_q) begin
              alu_go_q <= 1'b1;
            end
          end
          default: begin
            state_q <= ENTER_A;
            ready_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign porta     = porta_q;
  assign portb     = portb_q;
  assign aluop     = aluop_q;
  assign ready     = ready_q;
  assign alu_go    = alu_go_q;
  assign state_led = state_q;

endmodule

// File: tb/tb_alu_operand_entry.sv
// Randomized self-checking bench for alu_operand_entry against a transaction-level entry model.
module tb_alu_operand_entry;

  localparam int DEB = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [3:0]  KEY;
  logic [17:0] SW;
  logic [31:0] porta;
  logic [31:0] portb;
  logic [3:0]  aluop;
  logic        ready;
  logic        alu_go;
  logic [1:0]  state_led;

  int          n_vec = 0;
  int          n_err = 0;

  // Reference model state
  int          m_state = 0;
  logic [31:0] m_a = 32'h0;
  logic [31:0] m_b = 32'h0;
  logic [3:0]  m_op = 4'h0;
  int          m_go = 0;

  // Observed go pulses and protocol violations
  int          go_seen = 0;
  int          bad_cycles = 0;
  logic        go_prev = 1'b0;

  alu_operand_entry #(.DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .KEY      (KEY),
    .SW       (SW),
    .porta    (porta),
    .portb    (portb),
    .aluop    (aluop),
    .ready    (ready),
    .alu_go   (alu_go),
    .state_led(state_led)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (alu_go) go_seen++;
    if (alu_go && state_led != 2'b11) bad_cycles++;
    if (alu_go && go_prev) bad_cycles++;
    if (ready != (state_led == 2'b11)) bad_cycles++;
    go_prev = alu_go;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sext17(input logic [17:0] sw);
    logic signed [16:0] v;
    v = sw[16:0];
    return 32'(v);
  endfunction

  task automatic model_press(input logic [3:0] mask, input logic [17:0] sw);
    if (mask[1]) begin
      m_state = 0; m_a = 32'h0; m_b = 32'h0; m_op = 4'h0;
    end else if (mask[0]) begin
      case (m_state)
        0: begin m_a = sext17(sw); m_state = 1; end
        1: begin m_b = sext17(sw); m_state = 2; end
        2: begin m_op = sw[3:0]; m_state = 3; m_go++; end
        default: m_state = 0;
      endcase
    end else if (mask[2] && m_state == 3) begin
      m_go++;
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_a = 32'h0; m_b = 32'h0; m_op = 4'h0;
  endtask

  task automatic check_model(input string tag);
    check_val({tag, ".state"}, {30'h0, state_led}, 32'(m_state));
    check_val({tag, ".porta"}, porta, m_a);
    check_val({tag, ".portb"}, portb, m_b);
    check_val({tag, ".aluop"}, {28'h0, aluop}, {28'h0, m_op});
    check_val({tag, ".ready"}, {31'h0, ready}, {31'h0, (m_state == 3)});
    check_val({tag, ".go_cnt"}, 32'(go_seen), 32'(m_go));
    check_val({tag, ".protocol"}, 32'(bad_cycles), 32'h0);
  endtask

  task automatic press_key(input logic [3:0] mask, input logic [17:0] sw);
    SW = sw;
    repeat (3) @(negedge CLK);
    KEY = ~mask;
    repeat (10) @(negedge CLK);
    KEY = 4'hF;
    repeat (10) @(negedge CLK);
    model_press(mask, sw);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, ".porta"}, porta, 32'h0);
    check_val({tag, ".portb"}, portb, 32'h0);
    check_val({tag, ".misc"}, {24'h0, aluop, ready, alu_go, state_led}, 32'h0);
  endtask

  task automatic full_sequence(input string tag);
    press_key(4'b0001, 18'h1_0005);
    press_key(4'b0001, 18'h0_0003);
    press_key(4'b0001, 18'h0_0004);
    check_model(tag);
    check_val({tag, ".a_const"}, porta, 32'hFFFF_0005);
    check_val({tag, ".b_const"}, portb, 32'h0000_0003);
    check_val({tag, ".op_const"}, {28'h0, aluop}, 32'h4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, want finish before 2ms");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] masks [8];
    logic [3:0] mk;
    logic [17:0] sw;
    masks = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0101};

    nRST = 1'b0; KEY = 4'hF; SW = 18'h0;
    #1;
    check_zero_outputs("reset_init");
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    // Scenario 1: async reset mid-cycle after partial entry
    press_key(4'b0001, 18'h0_1234);
    check_model("pre_reset");
    @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    check_zero_outputs("reset_async");
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    // Scenario 2 with latency check on the first capture
    SW = 18'h1_0005;
    repeat (3) @(negedge CLK);
    KEY[0] = 1'b0;
    repeat (2 + DEB + 1) @(posedge CLK);
    #1 check_val("lat_before_capture", porta, 32'h0);
    @(posedge CLK);
    #1 check_val("lat_capture", porta, 32'hFFFF_0005);
    @(negedge CLK);
    repeat (4) @(negedge CLK);
    KEY = 4'hF;
    repeat (10) @(negedge CLK);
    model_press(4'b0001, 18'h1_0005);
    press_key(4'b0001, 18'h0_0003);
    press_key(4'b0001, 18'h0_0004);
    check_model("scn2");
    check_val("scn2.a_const", porta, 32'hFFFF_0005);
    check_val("scn2.go_const", 32'(go_seen), 32'h1);

    // Scenario 4: repeat then enter from READY
    press_key(4'b0100, 18'h0_0000);
    check_model("scn4_repeat");
    press_key(4'b0001, 18'h0_0000);
    check_model("scn4_enter");

    // Scenario 3: short glitch and bounce, then a clean hold
    @(negedge CLK);
    KEY[0] = 1'b0;
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 10; i++) begin
      KEY[0] = ~KEY[0];
      @(negedge CLK);
    end
    KEY = 4'hF;
    repeat (10) @(negedge CLK);
    check_model("scn3_glitch");
    press_key(4'b0001, 18'h0_8001);
    check_model("scn3_hold");

    // Scenario 5: enter and clear together in ENTER_OP
    press_key(4'b0001, 18'h1_7777);
    check_model("scn5_pre");
    press_key(4'b0011, 18'h0_0009);
    check_model("scn5");

    // Scenario 6: reset during ENTER_B, then a full sequence
    press_key(4'b0001, 18'h0_4242);
    @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    check_zero_outputs("scn6_reset");
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);
    full_sequence("scn6");

    // Randomized key/switch traffic
    for (int i = 0; i < 40; i++) begin
      mk = masks[$urandom_range(0, 7)];
      sw = 18'($urandom);
      press_key(mk, sw);
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
